// File: rtl/loop_cpu.sv
// loop_cpu: small multicycle sequencer with a wide register file, a data medium,
// a heap medium and an optional hardware loop stack.
// Optional feature macro: HW_LOOP_EN. When it is defined, the LOOP and ENDLOOP
// instructions drive a hardware loop stack. When it is undefined, LOOP and
// ENDLOOP act as NOPs and error_out is tied to 0.
module loop_cpu #(
    parameter int PROGRAM_LENGTH   = 256,
    parameter int DATA_LENGTH      = 2,
    parameter int HEAP_LENGTH      = 8192,
    parameter int X_SIZE           = 512,
    parameter int NUM_XREGS        = 4,
    parameter int LOOP_DEPTH       = 4,
    parameter int INSTRUCTION_SIZE = 16
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    output logic [$clog2(PROGRAM_LENGTH)-1:0] instruction_addr_out,
    output logic                              instruction_ready_out,
    input  logic [INSTRUCTION_SIZE-1:0]       instruction_in,
    input  logic                              instruction_valid_in,
    output logic [$clog2(DATA_LENGTH)-1:0]    data_addr_out,
    output logic                              data_read_enable_out,
    input  logic [X_SIZE-1:0]                 data_x_in,
    input  logic [X_SIZE-1:0]                 data_y_in,
    input  logic                              data_medium_finished_in,
    output logic [$clog2(HEAP_LENGTH)-1:0]    heap_addr_out,
    output logic                              heap_read_enable_out,
    output logic                              heap_write_enable_out,
    output logic [X_SIZE-1:0]                 heap_out,
    input  logic [X_SIZE-1:0]                 heap_in,
    input  logic                              heap_medium_finished_in,
    output logic [X_SIZE-1:0]                 inference_out,
    output logic                              inference_valid_out,
    output logic                              halted_out,
    output logic                              error_out
);
    localparam int I = $clog2(PROGRAM_LENGTH);
    localparam int D = $clog2(DATA_LENGTH);
    localparam int H = $clog2(HEAP_LENGTH);
    localparam int R = $clog2(NUM_XREGS);

    localparam logic [2:0] S_FETCH    = 3'd0;
    localparam logic [2:0] S_EXEC     = 3'd1;
    localparam logic [2:0] S_OPERAND  = 3'd2;
    localparam logic [2:0] S_MEM_WAIT = 3'd3;
    localparam logic [2:0] S_HALT     = 3'd4;

    localparam logic [4:0] OP_HALT    = 5'd1;
    localparam logic [4:0] OP_JUMP    = 5'd2;
    localparam logic [4:0] OP_LOOP    = 5'd3;
    localparam logic [4:0] OP_ENDLOOP = 5'd4;
    localparam logic [4:0] OP_SET_H   = 5'd5;
    localparam logic [4:0] OP_SET_D   = 5'd6;
    localparam logic [4:0] OP_LOAD_X  = 5'd7;
    localparam logic [4:0] OP_LOAD_Y  = 5'd8;
    localparam logic [4:0] OP_LOAD_H  = 5'd9;
    localparam logic [4:0] OP_STORE_H = 5'd10;
    localparam logic [4:0] OP_MOV     = 5'd11;
    localparam logic [4:0] OP_XOR     = 5'd12;
    localparam logic [4:0] OP_AND     = 5'd13;
    localparam logic [4:0] OP_OR      = 5'd14;
    localparam logic [4:0] OP_OUT     = 5'd15;

    logic [2:0]                  state;
    logic [I-1:0]                pc;
    logic [I-1:0]                pc_inc;
    logic [INSTRUCTION_SIZE-1:0] ir;
    logic                        ready;
    logic [D-1:0]                data_ptr;
    logic [H-1:0]                heap_ptr;
    logic [X_SIZE-1:0]           regs [NUM_XREGS];
    logic [X_SIZE-1:0]           inference;
    logic                        inference_valid;
    logic [4:0]                  opcode;
    logic [10:0]                 operand;
    logic [R-1:0]                rd;
    logic [R-1:0]                rs;
    logic                        is_data_op;
    logic                        mem_done;

`ifdef HW_LOOP_EN
    localparam int SPW = $clog2(LOOP_DEPTH + 1);
    localparam int LW  = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;
    logic [I-1:0]   loop_start [LOOP_DEPTH];
    logic [10:0]    loop_count [LOOP_DEPTH];
    logic [SPW-1:0] loop_sp;
    logic [LW-1:0]  push_idx;
    logic [LW-1:0]  top_idx;
    logic           error;

    assign push_idx  = LW'(loop_sp);
    assign top_idx   = LW'(loop_sp - 1'b1);
    assign error_out = error;
`else
    assign error_out = 1'b0;
`endif

    assign opcode     = ir[15:11];
    assign operand    = ir[10:0];
    assign rd         = operand[R-1:0];
    assign rs         = operand[2*R-1:R];
    assign pc_inc     = pc + 1'b1;
    assign is_data_op = (opcode == OP_LOAD_X) || (opcode == OP_LOAD_Y);
    assign mem_done   = is_data_op ? data_medium_finished_in : heap_medium_finished_in;

    // The operand word of SET_H sits right after the opcode word, so OPERAND fetches pc+1.
    assign instruction_addr_out  = (state == S_OPERAND) ? pc_inc : pc;
    assign instruction_ready_out = ready;
    assign data_addr_out         = data_ptr;
    assign heap_addr_out         = heap_ptr;
    assign heap_out              = regs[rd];
    assign data_read_enable_out  = (state == S_EXEC) && is_data_op;
    assign heap_read_enable_out  = (state == S_EXEC) && (opcode == OP_LOAD_H);
    assign heap_write_enable_out = (state == S_EXEC) && (opcode == OP_STORE_H);
    assign inference_out         = inference;
    assign inference_valid_out   = inference_valid;
    assign halted_out            = (state == S_HALT);

    // Sequencer: fetch/operand handshakes, single-cycle execute, memory waits and the loop stack.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state           <= S_FETCH;
            pc              <= '0;
            ir              <= '0;
            ready           <= 1'b0;
            data_ptr        <= '0;
            heap_ptr        <= '0;
            inference       <= '0;
            inference_valid <= 1'b0;
            for (int i = 0; i < NUM_XREGS; i++) regs[i] <= '0;
`ifdef HW_LOOP_EN
            loop_sp <= '0;
            error   <= 1'b0;
            for (int i = 0; i < LOOP_DEPTH; i++) begin
                loop_start[i] <= '0;
                loop_count[i] <= '0;
            end
`endif
        end else begin
            inference_valid <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (!ready) begin
                        ready <= 1'b1;
                    end else if (instruction_valid_in) begin
                        ir    <= instruction_in;
                        ready <= 1'b0;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    ready <= 1'b1;
                    pc    <= pc_inc;
                    case (opcode)
                        OP_HALT: begin
                            state <= S_HALT;
                            ready <= 1'b0;
                            pc    <= pc;
                        end
                        OP_JUMP:  pc <= I'(operand);
`ifdef HW_LOOP_EN
                        OP_LOOP: begin
                            if (loop_sp == SPW'(LOOP_DEPTH)) begin
                                error <= 1'b1;
                            end else begin
                                loop_start[push_idx] <= pc_inc;
                                loop_count[push_idx] <= (operand == 11'd0) ? 11'd1 : operand;
                                loop_sp              <= loop_sp + 1'b1;
                            end
                        end
                        OP_ENDLOOP: begin
                            if (loop_sp == '0) begin
                                error <= 1'b1;
                            end else if (loop_count[top_idx] > 11'd1) begin
                                loop_count[top_idx] <= loop_count[top_idx] - 1'b1;
                                pc                  <= loop_start[top_idx];
                            end else begin
                                loop_sp <= loop_sp - 1'b1;
                            end
                        end
`endif
                        OP_SET_H: begin
                            state <= S_OPERAND;
                            pc    <= pc;
                        end
                        OP_SET_D: data_ptr <= D'(operand);
                        OP_LOAD_X, OP_LOAD_Y, OP_LOAD_H, OP_STORE_H: begin
                            state <= S_MEM_WAIT;
                            ready <= 1'b0;
                            pc    <= pc;
                        end
                        OP_MOV: regs[rd] <= regs[rs];
                        OP_XOR: regs[rd] <= regs[rd] ^ regs[rs];
                        OP_AND: regs[rd] <= regs[rd] & regs[rs];
                        OP_OR:  regs[rd] <= regs[rd] | regs[rs];
                        OP_OUT: begin
                            inference       <= regs[rd];
                            inference_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_OPERAND: begin
                    if (instruction_valid_in) begin
                        heap_ptr <= H'(instruction_in);
                        pc       <= pc + I'(2);
                        state    <= S_FETCH;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_done) begin
                        case (opcode)
                            OP_LOAD_X: regs[rd] <= data_x_in;
                            OP_LOAD_Y: regs[rd] <= data_y_in;
                            OP_LOAD_H: regs[rd] <= heap_in;
                            default: ;
                        endcase
                        pc    <= pc_inc;
                        ready <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_HALT: ;
                default: state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: doc/loop_cpu.md
LOOP_CPU -- requirements
Module: loop_cpu

Interface
REQ-001 SHALL have parameter PROGRAM_LENGTH, default 256, instruction memory depth (power of two); pc width I=$clog2(PROGRAM_LENGTH).
REQ-002 SHALL have parameter DATA_LENGTH, default 2, data medium depth; D=$clog2(DATA_LENGTH).
REQ-003 SHALL have parameter HEAP_LENGTH, default 8192, heap depth; H=$clog2(HEAP_LENGTH).
REQ-004 SHALL have parameter X_SIZE, default 512, register width.
REQ-005 SHALL have parameter NUM_XREGS, default 4, register file size (2..16); R=$clog2(NUM_XREGS).
REQ-006 SHALL have parameter LOOP_DEPTH, default 4, hardware loop stack depth.
REQ-007 SHALL have parameter INSTRUCTION_SIZE, default 16; opcode=[15:11], operand=[10:0].
REQ-008 SHALL have ports: clk_in in 1 clock; rst_in in 1 reset, asynchronous, active-high.
REQ-009 SHALL have ports: instruction_addr_out out I; instruction_ready_out out 1; instruction_in in INSTRUCTION_SIZE; instruction_valid_in in 1.
REQ-010 SHALL have ports: data_addr_out out D; data_read_enable_out out 1; data_x_in in X_SIZE; data_y_in in X_SIZE; data_medium_finished_in in 1.
REQ-011 SHALL have ports: heap_addr_out out H; heap_read_enable_out out 1; heap_write_enable_out out 1; heap_out out X_SIZE; heap_in in X_SIZE; heap_medium_finished_in in 1.
REQ-012 SHALL have ports: inference_out out X_SIZE; inference_valid_out out 1; halted_out out 1; error_out out 1 (sticky).

Function
REQ-013 SHALL implement FSM FETCH, EXEC, OPERAND, MEM_WAIT, HALT; FETCH drives instruction_ready_out=1, instruction_addr_out=pc; capture instruction on instruction_valid_in, go EXEC.
REQ-014 SHALL execute register/control ops in EXEC in one cycle, then FETCH; pc+1 wraps mod PROGRAM_LENGTH.
REQ-015 Opcodes: 0 NOP; 1 HALT; 2 JUMP pc<=operand[I-1:0]; 3 LOOP; 4 ENDLOOP; 5 SET_H; 6 SET_D data pointer<=operand mod DATA_LENGTH; 7 LOAD_X; 8 LOAD_Y; 9 LOAD_H; 10 STORE_H; 11 MOV; 12 XOR; 13 AND; 14 OR; 15 OUT; 16-31 NOP, no error.
REQ-016 Register fields: rd=operand[R-1:0], rs=operand[2R-1:R]; MOV r[rd]<=r[rs]; XOR/AND/OR r[rd]<=r[rd] op r[rs].
REQ-017 SET_H SHALL go OPERAND, fetch word at pc+1 with same handshake, load heap pointer<=word[H-1:0], pc<=pc+2.
REQ-018 LOAD_X/LOAD_Y/LOAD_H/STORE_H SHALL pulse the relevant enable for exactly one cycle in EXEC, wait in MEM_WAIT until *_finished_in, latch read data into r[rd] (STORE_H writes r[rd] via heap_out) on that cycle, pc+1.
REQ-019 LOOP n SHALL push {start=pc+1, count=max(n,1)}; ENDLOOP with count>1 SHALL decrement and jump to start, else pop and pc+1.
REQ-020 LOOP with stack full or ENDLOOP with stack empty SHALL set error_out and act as NOP.
REQ-021 OUT SHALL drive inference_out<=r[rd] and pulse inference_valid_out one cycle.
REQ-022 HALT SHALL enter HALT, set halted_out=1, deassert all requests; only reset exits.

Reset
REQ-023 rst_in SHALL asynchronously clear pc, pointers, registers, loop stack, inference_out, error_out, all enables/valids/ready to 0 and state to FETCH, including mid-MEM_WAIT or mid-OPERAND.

Configuration
REQ-024 With HW_LOOP_EN defined the loop stack SHALL exist per REQ-019/020; without it LOOP/ENDLOOP SHALL execute as NOP, no stack logic synthesised, error_out stuck 0.

Verification
REQ-025 Program MOV/XOR with r0=0xF0,r1=0x0F, XOR r0,r1; OUT r0 -> inference_out=0xFF, valid one cycle.
REQ-026 LOOP 3, OUT r0, ENDLOOP, HALT -> exactly 3 valid pulses, then halted_out=1.
REQ-027 LOOP 0 body -> executes once; LOOP_DEPTH+1 nested LOOPs -> error_out=1, last ignored.
REQ-028 LOAD_H with heap_medium_finished_in delayed 5 cycles -> heap_read_enable_out one-cycle pulse, no fetch until done, r[rd]=heap_in.
REQ-029 rst_in asserted during MEM_WAIT -> all outputs 0 same edge-independent, next fetch at pc=0.
